// File: rtl/mem_bus_pkg.sv
// Shared definitions for the main-memory bus arbiter: state encoding,
// requester indices, default widths and the round-robin index helper.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    WACK  = 2'd2,
    RDATA = 2'd3
  } state_t;

  localparam int REQ_IMEM   = 0;
  localparam int REQ_DMEM_R = 1;
  localparam int REQ_DMEM_W = 2;
  localparam int REQ_SYS_R  = 3;

  localparam int NREQ_DEF  = 4;
  localparam int ADDRW_DEF = 32;
  localparam int DATAW_DEF = 32;
  localparam int LENW_DEF  = 2;

  // (base + off) modulo n, for base < n and off < n
  function automatic int rr_index(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_picker.sv
// Combinational winner selection. Round-robin from ptr by default;
// MEM_ARB_FIXED_PRIO_EN selects lowest-index fixed priority instead.
module rr_picker
  import mem_bus_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [PTRW-1:0] ptr,
  output logic            any,
  output logic [PTRW-1:0] winner
);

`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    any    = 1'b0;
    winner = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (valid[i]) begin
        any    = 1'b1;
        winner = PTRW'(i);
      end
    end
  end
`else
  // Scan backwards so the last overwrite is the first hit from ptr onward
  always_comb begin
    any    = 1'b0;
    winner = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (valid[rr_index(int'(ptr), i, NREQ)]) begin
        any    = 1'b1;
        winner = PTRW'(rr_index(int'(ptr), i, NREQ));
      end
    end
  end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing the main-memory bus among NREQ requesters;
// define MEM_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int ADDRW = ADDRW_DEF,
  parameter int DATAW = DATAW_DEF,
  parameter int LENW  = LENW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*ADDRW-1:0] req_addr,
  input  logic [NREQ-1:0]       req_wr_en,
  input  logic [NREQ*DATAW-1:0] req_wr_data,
  input  logic [NREQ*LENW-1:0]  req_len,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [DATAW-1:0]      rsp_data,
  output logic               mem_req,
  input  logic               mem_gnt,
  output logic [ADDRW-1:0]   mem_addr,
  output logic               mem_rd_wr,
  output logic [LENW-1:0]    mem_len,
  output logic [DATAW-1:0]   mem_wdata,
  input  logic               mem_wack,
  input  logic [DATAW-1:0]   mem_rdata,
  input  logic               mem_rdata_valid,
  output logic               mem_rdata_ready
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNTW = LENW + 1;

  state_t           state_reg, state_next;
  logic [ADDRW-1:0] addr_reg;
  logic             rd_wr_reg;
  logic [DATAW-1:0] wdata_reg;
  logic [LENW-1:0]  len_reg;
  logic [PTRW-1:0]  owner_reg;
  logic [CNTW-1:0]  beat_cnt_reg;
  logic             hold_full_reg;
  logic [DATAW-1:0] hold_data_reg;

  logic [PTRW-1:0]  pick_idx, pick_ptr;
  logic             pick_any, accept, load, drain, last_done;

  logic [ADDRW-1:0] addr_arr  [NREQ];
  logic [DATAW-1:0] wdata_arr [NREQ];
  logic [LENW-1:0]  len_arr   [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign addr_arr[gi]  = req_addr[gi*ADDRW +: ADDRW];
    assign wdata_arr[gi] = req_wr_data[gi*DATAW +: DATAW];
    assign len_arr[gi]   = req_len[gi*LENW +: LENW];
    assign req_ready[gi] = accept && (pick_idx == PTRW'(gi));
    assign rsp_valid[gi] = hold_full_reg && (owner_reg == PTRW'(gi));
  end

  rr_picker #(.NREQ(NREQ), .PTRW(PTRW)) u_picker (
    .valid  (req_valid),
    .ptr    (pick_ptr),
    .any    (pick_any),
    .winner (pick_idx)
  );

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign pick_ptr = '0;
`else
  logic [PTRW-1:0] rr_ptr_reg;
  assign pick_ptr = rr_ptr_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       rr_ptr_reg <= '0;
    else if (accept) rr_ptr_reg <= PTRW'(rr_index(int'(pick_idx), 1, NREQ));
  end
`endif

  assign accept    = (state_reg == IDLE) && pick_any;
  assign drain     = hold_full_reg && rsp_ready[owner_reg];
  assign load      = mem_rdata_valid && mem_rdata_ready;
  assign last_done = (beat_cnt_reg == (CNTW'(len_reg) + CNTW'(1)));

  assign mem_req   = (state_reg == ADDR);
  assign mem_addr  = addr_reg;
  assign mem_rd_wr = rd_wr_reg;
  assign mem_len   = len_reg;
  assign mem_wdata = wdata_reg;
  assign rsp_data  = hold_data_reg;

  always_comb begin
    state_next      = state_reg;
    mem_rdata_ready = 1'b0;
    case (state_reg)
      IDLE:  if (pick_any) state_next = ADDR;
      ADDR:  if (mem_gnt) state_next = rd_wr_reg ? RDATA : WACK;
      WACK:  if (mem_wack) state_next = IDLE;
      RDATA: begin
        // Once every beat has arrived, stop taking data and just drain
        mem_rdata_ready = !last_done && (!hold_full_reg || rsp_ready[owner_reg]);
        if (last_done && drain) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      rd_wr_reg     <= 1'b0;
      wdata_reg     <= '0;
      len_reg       <= '0;
      owner_reg     <= '0;
      beat_cnt_reg  <= '0;
      hold_full_reg <= 1'b0;
      hold_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg  <= addr_arr[pick_idx];
        rd_wr_reg <= !req_wr_en[pick_idx];
        wdata_reg <= wdata_arr[pick_idx];
        len_reg   <= len_arr[pick_idx];
        owner_reg <= pick_idx;
      end
      if (state_reg == ADDR && mem_gnt) begin
        beat_cnt_reg  <= '0;
        hold_full_reg <= 1'b0;
      end else if (state_reg == RDATA) begin
        if (load) begin
          hold_data_reg <= mem_rdata;
          beat_cnt_reg  <= beat_cnt_reg + CNTW'(1);
        end
        hold_full_reg <= load || (hold_full_reg && !drain);
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter; expectations honour
// MEM_ARB_FIXED_PRIO_EN when the bench is built with it.
module tb_mem_bus_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid, req_ready, req_wr_en, rsp_valid, rsp_ready;
  logic [127:0] req_addr, req_wr_data;
  logic [7:0]   req_len;
  logic [31:0]  rsp_data, mem_addr, mem_wdata, mem_rdata;
  logic         mem_req, mem_gnt, mem_rd_wr, mem_wack, mem_rdata_valid, mem_rdata_ready;
  logic [1:0]   mem_len;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wr_en(req_wr_en), .req_wr_data(req_wr_data), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
    .mem_rd_wr(mem_rd_wr), .mem_len(mem_len), .mem_wdata(mem_wdata),
    .mem_wack(mem_wack), .mem_rdata(mem_rdata),
    .mem_rdata_valid(mem_rdata_valid), .mem_rdata_ready(mem_rdata_ready)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic clear_inputs;
    req_valid = '0; req_addr = '0; req_wr_en = '0; req_wr_data = '0; req_len = '0;
    rsp_ready = '0; mem_gnt = 0; mem_wack = 0; mem_rdata = '0; mem_rdata_valid = 0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    settle();
    vec_cnt++;
    if ({req_ready, rsp_valid, mem_req, mem_rd_wr, mem_len, mem_rdata_ready} !== 13'd0) begin
      err_cnt++;
      $display("FAIL reset_ctrl: got %b required 0", {req_ready, rsp_valid, mem_req, mem_rd_wr, mem_len, mem_rdata_ready});
    end
    vec_cnt++;
    if ({mem_addr, mem_wdata, rsp_data} !== 96'd0) begin
      err_cnt++;
      $display("FAIL reset_data: addr=%h wdata=%h rsp=%h required 0", mem_addr, mem_wdata, rsp_data);
    end
    req_valid = 4'b0010; req_addr[32 +: 32] = 32'h0000_1234; req_len[2 +: 2] = 2'd1;
    tick();
    vec_cnt++;
    if (mem_req !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset_addr_phase: mem_req=%b required 1", mem_req);
    end
    #2 reset = 1'b1;
    #1;
    vec_cnt++;
    if (mem_req !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_async_drop: mem_req=%b required 0", mem_req);
    end
    tick();
    reset = 1'b0;
    req_valid = 4'b0000;
    settle();
    vec_cnt++;
    if ({req_ready, rsp_valid, mem_req, mem_rd_wr, mem_len, mem_rdata_ready, mem_addr} !== 45'd0) begin
      err_cnt++;
      $display("FAIL reset_release: got %h required 0", {req_ready, rsp_valid, mem_req, mem_rd_wr, mem_len, mem_rdata_ready, mem_addr});
    end
    req_valid = 4'b1010; req_addr[96 +: 32] = 32'h0000_0300;
    settle();
    vec_cnt++;
    if (req_ready !== 4'b0010) begin
      err_cnt++;
      $display("FAIL reset_rr_ptr: req_ready=%b required 0010", req_ready);
    end
    $display("txn reset: mid-address-phase reset of req1 read");
    do_reset();
  endtask

  task automatic test_single_read;
    logic [31:0] exp_d;
    req_valid = 4'b0001; req_addr[0 +: 32] = 32'h0000_2000; req_len[0 +: 2] = 2'd3; rsp_ready = 4'b0001;
    settle();
    vec_cnt++;
    if (req_ready !== 4'b0001 || mem_req !== 1'b0) begin
      err_cnt++;
      $display("FAIL rd_accept: req_ready=%b mem_req=%b required 0001/0", req_ready, mem_req);
    end
    tick();
    req_valid = 4'b0000;
    vec_cnt++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_2000 || {mem_rd_wr, mem_len} !== 3'b111) begin
      err_cnt++;
      $display("FAIL rd_addr_phase: req=%b addr=%h rw=%b len=%0d required 1/00002000/1/3", mem_req, mem_addr, mem_rd_wr, mem_len);
    end
    for (int c = 2; c <= 3; c++) begin
      tick();
      vec_cnt++;
      if (mem_req !== 1'b1 || req_ready !== 4'b0000 || mem_addr !== 32'h0000_2000) begin
        err_cnt++;
        $display("FAIL rd_req_hold c%0d: req=%b ready=%b addr=%h required 1/0000/00002000", c, mem_req, req_ready, mem_addr);
      end
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    vec_cnt++;
    if (mem_req !== 1'b0 || rsp_valid !== 4'b0000) begin
      err_cnt++;
      $display("FAIL rd_req_drop: mem_req=%b rsp_valid=%b required 0/0000", mem_req, rsp_valid);
    end
    for (int k = 0; k < 4; k++) begin
      exp_d = 32'h11 * 32'(k + 1);
      mem_rdata_valid = 1'b1; mem_rdata = exp_d;
      settle();
      vec_cnt++;
      if (mem_rdata_ready !== 1'b1) begin
        err_cnt++;
        $display("FAIL rd_beat_ready b%0d: mem_rdata_ready=%b required 1", k, mem_rdata_ready);
      end
      tick();
      vec_cnt++;
      if (rsp_valid !== 4'b0001 || rsp_data !== exp_d) begin
        err_cnt++;
        $display("FAIL rd_beat b%0d: rsp_valid=%b data=%h required 0001/%h", k, rsp_valid, rsp_data, exp_d);
      end
    end
    mem_rdata_valid = 1'b0;
    settle();
    vec_cnt++;
    if (mem_rdata_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL rd_last_ready: mem_rdata_ready=%b required 0", mem_rdata_ready);
    end
    tick();
    req_valid = 4'b0100;
    settle();
    vec_cnt++;
    if (rsp_valid !== 4'b0000 || req_ready !== 4'b0100) begin
      err_cnt++;
      $display("FAIL rd_back_idle: rsp_valid=%b req_ready=%b required 0000/0100", rsp_valid, req_ready);
    end
    $display("txn read: req0 addr 00002000 len 3, 4 beats");
    do_reset();
  endtask

  task automatic test_stall_read;
    req_valid = 4'b0010; req_addr[32 +: 32] = 32'h0000_3000; req_len[2 +: 2] = 2'd1;
    tick();
    req_valid = 4'b0000; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rdata_valid = 1'b1; mem_rdata = 32'hAAAA_0001;
    tick();
    mem_rdata = 32'hAAAA_0002;
    for (int c = 0; c < 5; c++) begin
      settle();
      vec_cnt++;
      if (mem_rdata_ready !== 1'b0 || rsp_valid !== 4'b0010 || rsp_data !== 32'hAAAA_0001) begin
        err_cnt++;
        $display("FAIL stall_hold c%0d: ready=%b rsp_valid=%b data=%h required 0/0010/aaaa0001", c, mem_rdata_ready, rsp_valid, rsp_data);
      end
      tick();
    end
    rsp_ready = 4'b0010;
    settle();
    vec_cnt++;
    if (mem_rdata_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL stall_release: mem_rdata_ready=%b required 1", mem_rdata_ready);
    end
    tick();
    mem_rdata_valid = 1'b0;
    settle();
    vec_cnt++;
    if (rsp_valid !== 4'b0010 || rsp_data !== 32'hAAAA_0002 || mem_rdata_ready !== 1'b0) begin
      err_cnt++;
      $display("FAIL stall_second: rsp_valid=%b data=%h ready=%b required 0010/aaaa0002/0", rsp_valid, rsp_data, mem_rdata_ready);
    end
    tick();
    vec_cnt++;
    if (rsp_valid !== 4'b0000) begin
      err_cnt++;
      $display("FAIL stall_done: rsp_valid=%b required 0000", rsp_valid);
    end
    $display("txn read: req1 addr 00003000 len 1, 5-cycle stall");
    do_reset();
  endtask

  task automatic test_write;
    req_valid = 4'b0100; req_wr_en = 4'b0100;
    req_addr[64 +: 32] = 32'h0000_B004; req_wr_data[64 +: 32] = 32'hDEAD_BEEF;
    settle();
    vec_cnt++;
    if (req_ready !== 4'b0100) begin
      err_cnt++;
      $display("FAIL wr_accept: req_ready=%b required 0100", req_ready);
    end
    tick();
    req_valid = 4'b0000; req_wr_data = '0;
    vec_cnt++;
    if (mem_req !== 1'b1 || mem_rd_wr !== 1'b0 || mem_addr !== 32'h0000_B004 || mem_wdata !== 32'hDEAD_BEEF) begin
      err_cnt++;
      $display("FAIL wr_addr_phase: req=%b rw=%b addr=%h wdata=%h required 1/0/0000b004/deadbeef", mem_req, mem_rd_wr, mem_addr, mem_wdata);
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) mem_wack = 1'b1;
      settle();
      vec_cnt++;
      if (mem_req !== 1'b0 || rsp_valid !== 4'b0000 || mem_wdata !== 32'hDEAD_BEEF || req_ready !== 4'b0000) begin
        err_cnt++;
        $display("FAIL wr_wack c%0d: req=%b rsp_valid=%b wdata=%h ready=%b required 0/0000/deadbeef/0000", c, mem_req, rsp_valid, mem_wdata, req_ready);
      end
      tick();
    end
    mem_wack = 1'b0;
    req_valid = 4'b0001;
    settle();
    vec_cnt++;
    if (req_ready !== 4'b0001 || rsp_valid !== 4'b0000) begin
      err_cnt++;
      $display("FAIL wr_back_idle: req_ready=%b rsp_valid=%b required 0001/0000", req_ready, rsp_valid);
    end
    $display("txn write: req2 addr 0000b004 data deadbeef");
    do_reset();
  endtask

  task automatic test_rr_order;
    logic [3:0] exp_rdy;
    req_valid = 4'b1111; rsp_ready = 4'b1111;
    for (int t = 0; t < 5; t++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_rdy = 4'b0001;
`else
      exp_rdy = 4'b0001 << (t % 4);
`endif
      settle();
      vec_cnt++;
      if (req_ready !== exp_rdy) begin
        err_cnt++;
        $display("FAIL rr_grant t%0d: req_ready=%b required %b", t, req_ready, exp_rdy);
      end
      tick();
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0; mem_rdata_valid = 1'b1; mem_rdata = 32'h100 + 32'(t);
      tick();
      mem_rdata_valid = 1'b0;
      vec_cnt++;
      if (rsp_valid !== exp_rdy || rsp_data !== 32'h100 + 32'(t)) begin
        err_cnt++;
        $display("FAIL rr_rsp t%0d: rsp_valid=%b data=%h required %b/%h", t, rsp_valid, rsp_data, exp_rdy, 32'h100 + 32'(t));
      end
      tick();
      $display("txn rr: grant %b single-beat read", exp_rdy);
    end
    do_reset();
  endtask

  task automatic test_final_drain;
    req_valid = 4'b0010; req_addr[32 +: 32] = 32'h0000_4000;
    tick();
    req_valid = 4'b0000; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rdata_valid = 1'b1; mem_rdata = 32'h5555_0001;
    tick();
    mem_rdata_valid = 1'b0;
    rsp_ready = 4'b0010; req_valid = 4'b1000; req_addr[96 +: 32] = 32'h0000_5000;
    settle();
    vec_cnt++;
    if (req_ready !== 4'b0000 || rsp_valid !== 4'b0010 || rsp_data !== 32'h5555_0001) begin
      err_cnt++;
      $display("FAIL drain_cycle: ready=%b rsp_valid=%b data=%h required 0000/0010/55550001", req_ready, rsp_valid, rsp_data);
    end
    tick();
    vec_cnt++;
    if (req_ready !== 4'b1000 || rsp_valid !== 4'b0000 || mem_req !== 1'b0) begin
      err_cnt++;
      $display("FAIL drain_next_accept: ready=%b rsp_valid=%b mem_req=%b required 1000/0000/0", req_ready, rsp_valid, mem_req);
    end
    tick();
    vec_cnt++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_5000) begin
      err_cnt++;
      $display("FAIL drain_req3_addr: mem_req=%b addr=%h required 1/00005000", mem_req, mem_addr);
    end
    $display("txn read: req1 final drain, req3 accepted next cycle");
    do_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    test_reset();
    test_single_read();
    test_stall_read();
    test_write();
    test_rr_order();
    test_final_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single 32-bit main-memory bus between the memory subsystem's requesters: imem fill, dmem read, dmem write and sys read.
- Accepts one transaction at a time from NREQ requesters using round-robin arbitration.
- Drives a request/grant bus handshake, then either sequences a multi-beat read burst back to the owning requester or completes a single-beat write.
- Sits inside memory_subsystem_top, between the cache/TLB front ends and the main-memory interconnect.

Parameters:
- NREQ, 4, number of requesters (index 0 = imem, 1 = dmem_r, 2 = dmem_w, 3 = sys_r).
- ADDRW, 32, bus address width.
- DATAW, 32, bus data width (one beat).
- LENW, 2, burst length field width; beats = len+1, maximum 4 (one 128-bit line).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  request valid, one bit per requester.
- req_ready  out  NREQ  request accepted (one-hot, single cycle).
- req_addr  in  NREQ*ADDRW  flattened request addresses; requester i occupies [i*ADDRW +: ADDRW].
- req_wr_en  in  NREQ  1 = write, 0 = read.
- req_wr_data  in  NREQ*DATAW  flattened write data.
- req_len  in  NREQ*LENW  read beats minus 1; ignored for writes.
- rsp_valid  out  NREQ  read beat valid, one-hot to the owner.
- rsp_ready  in  NREQ  requester accepts the read beat.
- rsp_data  out  DATAW  read beat data, shared by all requesters.
- mem_req  out  1  bus request.
- mem_gnt  in  1  bus grant; address phase completes on mem_req & mem_gnt.
- mem_addr  out  ADDRW  base address, held for the whole transaction.
- mem_rd_wr  out  1  1 = read, 0 = write.
- mem_len  out  LENW  burst length.
- mem_wdata  out  DATAW  write data.
- mem_wack  in  1  write complete.
- mem_rdata  in  DATAW  read beat.
- mem_rdata_valid  in  1  read beat present; transfers only when mem_rdata_ready is high.
- mem_rdata_ready  out  1  arbiter can take a beat.

Behaviour:
- Reset: all outputs 0, state IDLE, rr_ptr = 0, hold_full = 0, beat_cnt = 0. Reset mid-transaction abandons it; mem_req drops asynchronously.
- States: IDLE, ADDR, WACK, RDATA.
- IDLE, arbitration:
  - If any req_valid is high, the winner is the first set bit scanning rr_ptr, rr_ptr+1, … modulo NREQ.
  - req_ready[winner] = 1 combinationally in the same cycle; it is the only accept point.
  - On that clock: latch addr, wr_en, wr_data, len and owner; rr_ptr <= (winner+1) mod NREQ; go to ADDR.
- ADDR:
  - mem_req = 1; mem_addr, mem_rd_wr, mem_len and mem_wdata are stable until mem_gnt.
  - On mem_gnt, mem_req drops the next cycle. Write goes to WACK; read goes to RDATA with beat_cnt = 0.
- WACK: wait for mem_wack, then go to IDLE. No rsp_valid is produced for writes.
- RDATA:
  - One-entry hold register; mem_rdata_ready = ~hold_full | rsp_ready[owner].
  - Beat transfer (mem_rdata_valid & mem_rdata_ready) loads the hold register and increments beat_cnt.
  - rsp_valid[owner] = hold_full; rsp_data = hold register.
  - Simultaneous drain and load keeps hold_full = 1.
  - When beat_cnt == len+1 and the hold register drains: go to IDLE and force mem_rdata_ready = 0 after the last beat.
- Latency:
  - Accept at cycle 0; mem_req is high at cycle 1.
  - Back-to-back transactions always pass through IDLE (one bubble cycle). A request arriving during the final drain is arbitrated next cycle.
- Non-owner rsp_valid bits are always 0; req_ready is never asserted outside IDLE.
- rr_ptr wraps from NREQ-1 to 0.

Optional Feature:
- MEM_ARB_FIXED_PRIO_EN.
  - Defined: fixed priority; the lowest-index valid requester always wins and rr_ptr is not implemented.
  - Undefined: round-robin as above.

Decomposition:
- Shared package mem_bus_pkg: state encoding (IDLE, ADDR, WACK, RDATA), requester index constants (REQ_IMEM = 0, REQ_DMEM_R = 1, REQ_DMEM_W = 2, REQ_SYS_R = 3), default widths.
- Sub-module rr_picker: combinational winner from valid and ptr, with the fixed-priority variant selected by the macro.

Test Plan:
- Reset while in ADDR with req 1 pending → mem_req = 0 immediately; after release, rr_ptr = 0 and all outputs are 0.
- Single read, req 0, addr 0x0000_2000, len 3, mem_gnt after 2 cycles, beats 0x11, 0x22, 0x33, 0x44 with rsp_ready = 1 → req_ready[0] at cycle 0, mem_req cycles 1–3, four rsp_valid[0] beats in order, then IDLE.
- Read len 1 with rsp_ready[1] held low 5 cycles → hold register keeps 0xAAAA_0001, mem_rdata_ready = 0 while full, no beat lost or duplicated.
- Write req 2, addr 0x0000_B004, data 0xDEAD_BEEF, mem_wack 3 cycles after grant → mem_rd_wr = 0, mem_wdata stable, no rsp_valid, back to IDLE.
- All four req_valid held high, single-beat reads → grant order 0, 1, 2, 3, 0; with MEM_ARB_FIXED_PRIO_EN defined → order 0, 0, 0, ….
- Request from req 3 arriving on the final drain cycle of a req 1 read → req_ready[3] asserted exactly one cycle later, in IDLE.
